// File: rtl/s38417_sel_scan_ctrl.sv
// Three-phase select/compare scan sequencer: walks masked 3-bit flag entries and reports hits over hit/ack.
// Optional hit counter output enabled by defining SEL_SCAN_HITCNT_EN.
module s38417_sel_scan_ctrl #(
  parameter int N_ENT = 14,
  parameter int IDX_W = 4
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [3*N_ENT-1:0]     entries,
  input  logic [N_ENT-1:0]       mask,
  input  logic                   ack,
  output logic [2:0]             sel,
  output logic                   busy,
  output logic                   hit,
  output logic [IDX_W-1:0]       hit_idx,
  output logic [1:0]             hit_ph,
  output logic                   done
`ifdef SEL_SCAN_HITCNT_EN
  ,
  output logic [IDX_W+1:0]       hit_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // SCAN  | evaluating one (idx, ph) position per cycle
  // HIT   | match pending, waiting for ack
  // DONE  | one-cycle end-of-scan pulse
  typedef enum logic [1:0] {IDLE, SCAN, HIT, DONE} state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENT - 1);

  state_t                    state, state_n;
  logic [IDX_W-1:0]          idx, idx_n, idx_adv;
  logic [1:0]                ph, ph_n, ph_adv;
  logic [N_ENT-1:0][2:0]     ent_s, ent_n;
  logic [N_ENT-1:0]          mask_s, mask_n;
  logic [2:0]                sel_n;
  logic                      busy_n, hit_n, done_n;
  logic [IDX_W-1:0]          hit_idx_n;
  logic [1:0]                hit_ph_n;
  logic                      match, last_pos;
`ifdef SEL_SCAN_HITCNT_EN
  logic [IDX_W+1:0]          hit_cnt_n;
`endif

  assign match    = mask_s[idx] & ent_s[idx][ph];
  assign last_pos = (ph == 2'd2) && (idx == IDX_LAST);

  // idx runs fastest; ph only steps when idx wraps, so neither reaches an unused code
  always_comb begin
    if (idx == IDX_LAST) begin
      idx_adv = '0;
      ph_adv  = ph + 2'd1;
    end else begin
      idx_adv = idx + 1'b1;
      ph_adv  = ph;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    ph_n      = ph;
    ent_n     = ent_s;
    mask_n    = mask_s;
    sel_n     = sel;
    busy_n    = busy;
    hit_n     = hit;
    hit_idx_n = hit_idx;
    hit_ph_n  = hit_ph;
    done_n    = 1'b0;
`ifdef SEL_SCAN_HITCNT_EN
    hit_cnt_n = hit_cnt;
`endif
    case (state)
      IDLE: begin
        sel_n  = 3'b000;
        busy_n = 1'b0;
        if (start) begin
          state_n = SCAN;
          idx_n   = '0;
          ph_n    = 2'd0;
          ent_n   = entries;
          mask_n  = mask;
          sel_n   = 3'b001;
          busy_n  = 1'b1;
`ifdef SEL_SCAN_HITCNT_EN
          hit_cnt_n = '0;
`endif
        end
      end
      SCAN: begin
        if (match) begin
          state_n   = HIT;
          hit_n     = 1'b1;
          hit_idx_n = idx;
          hit_ph_n  = ph;
        end else if (last_pos) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          sel_n   = 3'b000;
        end else begin
          idx_n = idx_adv;
          ph_n  = ph_adv;
          sel_n = 3'b001 << ph_adv;
        end
      end
      HIT: begin
        if (ack) begin
          hit_n = 1'b0;
`ifdef SEL_SCAN_HITCNT_EN
          if (hit_cnt != '1) hit_cnt_n = hit_cnt + 1'b1;
`endif
          if (last_pos) begin
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            sel_n   = 3'b000;
          end else begin
            state_n = SCAN;
            idx_n   = idx_adv;
            ph_n    = ph_adv;
            sel_n   = 3'b001 << ph_adv;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        sel_n   = 3'b000;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      idx     <= '0;
      ph      <= 2'd0;
      ent_s   <= '0;
      mask_s  <= '0;
      sel     <= 3'b000;
      busy    <= 1'b0;
      hit     <= 1'b0;
      hit_idx <= '0;
      hit_ph  <= 2'd0;
      done    <= 1'b0;
`ifdef SEL_SCAN_HITCNT_EN
      hit_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      ph      <= ph_n;
      ent_s   <= ent_n;
      mask_s  <= mask_n;
      sel     <= sel_n;
      busy    <= busy_n;
      hit     <= hit_n;
      hit_idx <= hit_idx_n;
      hit_ph  <= hit_ph_n;
      done    <= done_n;
`ifdef SEL_SCAN_HITCNT_EN
      hit_cnt <= hit_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_s38417_sel_scan_ctrl.sv
// Self-checking bench for s38417_sel_scan_ctrl: directed and random scans against a position-list model.
module tb_s38417_sel_scan_ctrl;

  localparam int N = 14;
  localparam int NPOS = 3 * N;

  logic            CK = 1'b0;
  logic            RST = 1'b1;
  logic            start = 1'b0;
  logic [3*N-1:0]  entries = '0;
  logic [N-1:0]    mask = '0;
  logic            ack = 1'b0;
  logic [2:0]      sel;
  logic            busy, hit, done;
  logic [3:0]      hit_idx;
  logic [1:0]      hit_ph;
`ifdef SEL_SCAN_HITCNT_EN
  logic [5:0]      hit_cnt;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  string cur = "init";

  s38417_sel_scan_ctrl #(.N_ENT(N), .IDX_W(4)) dut (
    .CK(CK), .RST(RST), .start(start), .entries(entries), .mask(mask), .ack(ack),
    .sel(sel), .busy(busy), .hit(hit), .hit_idx(hit_idx), .hit_ph(hit_ph), .done(done)
`ifdef SEL_SCAN_HITCNT_EN
    , .hit_cnt(hit_cnt)
`endif
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Expected behaviour: the 3*N positions are visited in order p = ph*N + idx; each matching
  // position (judged on the start-time snapshot) raises hit until ack, then the scan moves on.
  task automatic run_scan(input logic [3*N-1:0] ent, input logic [N-1:0] msk, input int wait_n);
    logic [NPOS-1:0] hp;
    int nh;
    int w;
    for (int p = 0; p < NPOS; p++) hp[p] = msk[p % N] & ent[3 * (p % N) + p / N];
    entries = ent;
    mask    = msk;
    start   = 1'b1;
    tick();
    start = 1'b0;
    nh = 0;
    for (int p = 0; p < NPOS; p++) begin
      chk("scan_sel", sel, 64'(3'b001 << (p / N)));
      chk("scan_busy", busy, 1);
      chk("scan_hit", hit, 0);
      chk("scan_done", done, 0);
`ifdef SEL_SCAN_HITCNT_EN
      if (p == 0) chk("cnt_clear", hit_cnt, 0);
`endif
      entries = {$urandom, $urandom};
      mask    = N'($urandom);
      start   = 1'($urandom_range(0, 1));
      ack     = 1'($urandom_range(0, 1));
      tick();
      if (hp[p]) begin
        chk("hit", hit, 1);
        chk("hit_idx", hit_idx, p % N);
        chk("hit_ph", hit_ph, p / N);
        chk("hit_sel", sel, 64'(3'b001 << (p / N)));
        chk("hit_busy", busy, 1);
        w = (wait_n < 0) ? int'($urandom_range(0, 3)) : wait_n;
        ack = 1'b0;
        for (int k = 0; k < w; k++) begin
          start = 1'($urandom_range(0, 1));
          tick();
          chk("hold_hit", hit, 1);
          chk("hold_idx", hit_idx, p % N);
          chk("hold_ph", hit_ph, p / N);
          chk("hold_sel", sel, 64'(3'b001 << (p / N)));
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        nh++;
      end
    end
    ack = 1'b0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_sel", sel, 0);
    chk("end_hit", hit, 0);
`ifdef SEL_SCAN_HITCNT_EN
    chk("hit_cnt", hit_cnt, nh);
`endif
    start = 1'b1;
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    start = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_sel", sel, 0);
  endtask

  initial begin
    logic [3*N-1:0] e;
    logic [N-1:0]   m;
    int             guard;

    cur = "reset";
    #2;
    chk("sel", sel, 0);
    chk("busy", busy, 0);
    chk("hit", hit, 0);
    chk("hit_idx", hit_idx, 0);
    chk("hit_ph", hit_ph, 0);
    chk("done", done, 0);
    @(negedge CK);
    RST = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    cur = "no_entries";
    run_scan('0, '1, 0);

    cur = "single_hit";
    e = '0;
    e[3 * 5 + 1] = 1'b1;
    m = '0;
    m[5] = 1'b1;
    run_scan(e, m, 10);

    cur = "last_pos";
    e = '0;
    e[3 * 13 + 2] = 1'b1;
    run_scan(e, '1, 2);

    cur = "mask_zero";
    run_scan('1, '0, 0);

    cur = "four_hits";
    e = '0;
    e[3 * 0 + 0] = 1'b1;
    e[3 * 13 + 0] = 1'b1;
    e[3 * 7 + 1] = 1'b1;
    e[3 * 2 + 2] = 1'b1;
    e[3 * 9 + 2] = 1'b1;
    m = '1;
    m[9] = 1'b0;
    run_scan(e, m, -1);

    cur = "all_hits";
    run_scan('1, '1, 0);

    for (int r = 0; r < 6; r++) begin
      cur = $sformatf("rand%0d", r);
      e = {$urandom, $urandom} & {$urandom, $urandom};
      m = N'($urandom);
      run_scan(e, m, -1);
    end

    cur = "reset_in_hit";
    e = '0;
    e[3 * 5 + 1] = 1'b1;
    entries = e;
    mask = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (hit !== 1'b1 && guard < 60) begin
      tick();
      guard++;
    end
    chk("hit_seen", guard < 60, 1);
    RST = 1'b1;
    #1;
    chk("sel", sel, 0);
    chk("busy", busy, 0);
    chk("hit", hit, 0);
    chk("hit_idx", hit_idx, 0);
    chk("hit_ph", hit_ph, 0);
    @(negedge CK);
    RST = 1'b0;
    tick();
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_hit", hit, 0);

    cur = "after_reset";
    run_scan(e, '1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
